// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache/memory arbiter slice.
// State codes are plain localparams so older tools can consume them unchanged.
package core_pkg;

    localparam int LINE_WORDS = 8;
    localparam int WORD_BITS  = 32;
    localparam int LINE_BITS  = 256;
    localparam int ADDR_BITS  = 32;

    typedef logic [2:0] arbiter_state_e;

    localparam arbiter_state_e IDLE     = 3'd0;
    localparam arbiter_state_e RD_ISSUE = 3'd1;
    localparam arbiter_state_e RD_BEATS = 3'd2;
    localparam arbiter_state_e WR_ISSUE = 3'd3;
    localparam arbiter_state_e WR_WAIT  = 3'd4;
    localparam arbiter_state_e REPAIR   = 3'd5;
    localparam arbiter_state_e DONE     = 3'd6;

    function automatic logic [ADDR_BITS-1:0] line_align(input logic [ADDR_BITS-1:0] a);
        return a & ~32'h0000_001F;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_line_assembler.sv
// Collects eight 32-bit read beats into one 256-bit line, beat k landing in word k.
// line_next exposes the post-edge value so the caller can capture the final beat in the same cycle.
module line_assembler
    import core_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 beat_valid,
    input  logic [WORD_BITS-1:0] beat_data,
    output logic [LINE_BITS-1:0] line_next,
    output logic                 last_beat
);

    logic [2:0]           count_q, count_d;
    logic [LINE_BITS-1:0] line_q, line_d;

    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
            assign line_d[gi*WORD_BITS +: WORD_BITS] =
                clear ? '0 :
                (beat_valid && (count_q == 3'(gi))) ? beat_data :
                line_q[gi*WORD_BITS +: WORD_BITS];
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 3'd0;
        end else if (beat_valid) begin
            count_d = count_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 3'd0;
            line_q  <= '0;
        end else begin
            count_q <= count_d;
            line_q  <= line_d;
        end
    end

    assign line_next = line_d;
    assign last_beat = beat_valid && !clear && (count_q == 3'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-side fills and D-side fills/writebacks onto a single memory link,
// one transaction at a time, with address repair for read and write misses.
module cache_mem_arbiter
    import core_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req,
    input  logic [ADDR_BITS-1:0] i_addr,
    output logic                 i_done,
    output logic [LINE_BITS-1:0] i_line,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic [LINE_BITS-1:0] d_wdata,
    input  logic [31:0]          d_wmask,
    output logic                 d_done,
    output logic [LINE_BITS-1:0] d_line,
    output logic                 raddr_valid,
    output logic [ADDR_BITS-1:0] raddr,
    input  logic [WORD_BITS-1:0] rdata,
    input  logic                 rdata_valid,
    output logic                 waddr_valid,
    output logic [ADDR_BITS-1:0] waddr,
    output logic [LINE_BITS-1:0] wdata,
    output logic [31:0]          wmask,
    input  logic                 read_repair_request,
    input  logic                 write_miss_repair,
    input  logic [ADDR_BITS-1:0] missed_addr,
    output logic                 repair_resolved
);

    arbiter_state_e       state_q, state_d;
    logic                 side_q, side_d;      // 0: I-side, 1: D-side
    logic                 we_q, we_d;
    logic                 prio_q, prio_d;      // fill side favoured on the next tie
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic [31:0]          wmask_q, wmask_d;
    logic [LINE_BITS-1:0] i_line_q, i_line_d;
    logic [LINE_BITS-1:0] d_line_q, d_line_d;

    logic                 asm_clear;
    logic                 asm_beat;
    logic [LINE_BITS-1:0] asm_line_next;
    logic                 asm_last;

    // A repair request discards the beat presented alongside it.
    assign asm_clear = (state_q != RD_BEATS) || read_repair_request;
    assign asm_beat  = (state_q == RD_BEATS) && rdata_valid && !read_repair_request;

    line_assembler u_line_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (asm_clear),
        .beat_valid (asm_beat),
        .beat_data  (rdata),
        .line_next  (asm_line_next),
        .last_beat  (asm_last)
    );

    always_comb begin
        state_d  = state_q;
        side_d   = side_q;
        we_d     = we_q;
        prio_d   = prio_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        i_line_d = i_line_q;
        d_line_d = d_line_q;
        case (state_q)
            IDLE: begin
                if (d_req && d_we) begin
                    side_d  = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = line_align(d_addr);
                    wdata_d = d_wdata;
                    wmask_d = d_wmask;
                    state_d = WR_ISSUE;
                end else if (i_req && (!d_req || !prio_q)) begin
                    side_d  = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = line_align(i_addr);
                    prio_d  = 1'b1;
                    state_d = RD_ISSUE;
                end else if (d_req) begin
                    side_d  = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = line_align(d_addr);
                    prio_d  = 1'b0;
                    state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: state_d = RD_BEATS;
            RD_BEATS: begin
                if (read_repair_request) begin
                    state_d = REPAIR;
                end else if (asm_last) begin
                    if (side_q) d_line_d = asm_line_next;
                    else        i_line_d = asm_line_next;
                    state_d = DONE;
                end
            end
            WR_ISSUE: state_d = WR_WAIT;
            WR_WAIT:  state_d = write_miss_repair ? REPAIR : DONE;
            REPAIR: begin
                addr_d  = line_align(missed_addr);
                state_d = we_q ? WR_ISSUE : RD_ISSUE;
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            side_q   <= 1'b0;
            we_q     <= 1'b0;
            prio_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            i_line_q <= '0;
            d_line_q <= '0;
        end else begin
            state_q  <= state_d;
            side_q   <= side_d;
            we_q     <= we_d;
            prio_q   <= prio_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            i_line_q <= i_line_d;
            d_line_q <= d_line_d;
        end
    end

    // Strobes decode from distinct states, so read and write can never coincide.
    assign raddr_valid     = (state_q == RD_ISSUE);
    assign raddr           = raddr_valid ? addr_q : '0;
    assign waddr_valid     = (state_q == WR_ISSUE);
    assign waddr           = waddr_valid ? addr_q  : '0;
    assign wdata           = waddr_valid ? wdata_q : '0;
    assign wmask           = waddr_valid ? wmask_q : '0;
    assign repair_resolved = (state_q == REPAIR);
    assign i_done          = (state_q == DONE) && !side_q;
    assign d_done          = (state_q == DONE) && side_q;
    assign i_line          = i_line_q;
    assign d_line          = d_line_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized self-checking bench for cache_mem_arbiter; a memory-side responder
// supplies beats and the expected line is assembled from the beats sent.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_req = 1'b0;
    logic [31:0]  i_addr = '0;
    logic         i_done;
    logic [255:0] i_line;
    logic         d_req = 1'b0;
    logic         d_we = 1'b0;
    logic [31:0]  d_addr = '0;
    logic [255:0] d_wdata = '0;
    logic [31:0]  d_wmask = '0;
    logic         d_done;
    logic [255:0] d_line;
    logic         raddr_valid;
    logic [31:0]  raddr;
    logic [31:0]  rdata = '0;
    logic         rdata_valid = 1'b0;
    logic         waddr_valid;
    logic [31:0]  waddr;
    logic [255:0] wdata;
    logic [31:0]  wmask;
    logic         read_repair_request = 1'b0;
    logic         write_miss_repair = 1'b0;
    logic [31:0]  missed_addr = '0;
    logic         repair_resolved;

    int tests_run = 0;
    int fails = 0;

    logic [31:0]  beats [8];
    logic [255:0] exp_line;

    int i_done_cnt = 0, d_done_cnt = 0, rd_cnt = 0, wr_cnt = 0, rep_cnt = 0, overlap_cnt = 0;

    cache_mem_arbiter dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_req               (i_req),
        .i_addr              (i_addr),
        .i_done              (i_done),
        .i_line              (i_line),
        .d_req               (d_req),
        .d_we                (d_we),
        .d_addr              (d_addr),
        .d_wdata             (d_wdata),
        .d_wmask             (d_wmask),
        .d_done              (d_done),
        .d_line              (d_line),
        .raddr_valid         (raddr_valid),
        .raddr               (raddr),
        .rdata               (rdata),
        .rdata_valid         (rdata_valid),
        .waddr_valid         (waddr_valid),
        .waddr               (waddr),
        .wdata               (wdata),
        .wmask               (wmask),
        .read_repair_request (read_repair_request),
        .write_miss_repair   (write_miss_repair),
        .missed_addr         (missed_addr),
        .repair_resolved     (repair_resolved)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (i_done) i_done_cnt <= i_done_cnt + 1;
        if (d_done) d_done_cnt <= d_done_cnt + 1;
        if (raddr_valid) rd_cnt <= rd_cnt + 1;
        if (waddr_valid) wr_cnt <= wr_cnt + 1;
        if (repair_resolved) rep_cnt <= rep_cnt + 1;
        if (raddr_valid && waddr_valid) overlap_cnt <= overlap_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        rdata_valid = 1'b0; read_repair_request = 1'b0; write_miss_repair = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic wait_rd(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (raddr_valid) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    task automatic wait_wr(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (waddr_valid) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    task automatic make_beats;
        for (int k = 0; k < 8; k++) begin
            beats[k] = $urandom;
            exp_line[32*k +: 32] = beats[k];
        end
    endtask

    // Presents beats lo..hi-1 with random idle gaps; returns on the negedge after the last one.
    task automatic send_beats(input int lo, input int hi);
        for (int k = lo; k < hi; k++) begin
            repeat ($urandom_range(0, 2)) tick;
            rdata = beats[k];
            rdata_valid = 1'b1;
            tick;
            rdata_valid = 1'b0;
            rdata = $urandom;
        end
    endtask

    task automatic test_reset;
        logic [1060:0] all_out;
        rst_n = 1'b0;
        i_req = 1'b1;
        i_addr = 32'h0000_1234;
        repeat (3) tick;
        all_out = {raddr_valid, waddr_valid, i_done, d_done, repair_resolved,
                   raddr, waddr, wmask, wdata, i_line, d_line};
        tests_run++;
        if (all_out !== '0) begin
            fails++;
            $display("FAIL reset_outputs: raddr_valid=%b waddr_valid=%b done=%b%b rr=%b raddr=%h, required all 0",
                     raddr_valid, waddr_valid, i_done, d_done, repair_resolved, raddr);
        end
        rst_n = 1'b1;
        i_req = 1'b0;
        tick;
        tick;
        tests_run++;
        if (raddr_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_issue: raddr_valid=%b, required 0", raddr_valid);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_ifill;
        bit ok;
        int rd0, rep0, id0;
        do_reset;
        rd0 = rd_cnt; rep0 = rep_cnt; id0 = i_done_cnt;
        for (int k = 0; k < 8; k++) begin
            beats[k] = 32'hA0 + 32'(k);
            exp_line[32*k +: 32] = beats[k];
        end
        write_miss_repair = 1'b1;
        i_req = 1'b1;
        i_addr = 32'h1000_0004;
        wait_rd(ok);
        tests_run++;
        if (!ok) begin fails++; $display("FAIL ifill_issue: raddr_valid never seen, required 1"); end
        tests_run++;
        if (raddr !== 32'h1000_0000) begin fails++; $display("FAIL ifill_raddr: got %h, required 10000000", raddr); end
        rdata = 32'hDEAD_BEEF;
        rdata_valid = 1'b1;
        tick;
        rdata_valid = 1'b0;
        tests_run++;
        if (raddr_valid !== 1'b0) begin fails++; $display("FAIL ifill_raddr_pulse: raddr_valid=%b, required 0", raddr_valid); end
        send_beats(0, 7);
        tests_run++;
        if (i_done !== 1'b0) begin fails++; $display("FAIL ifill_early_done: i_done=%b before beat 7, required 0", i_done); end
        send_beats(7, 8);
        tests_run++;
        if (i_done !== 1'b1 || d_done !== 1'b0) begin
            fails++; $display("FAIL ifill_done: i_done=%b d_done=%b, required 1 0", i_done, d_done);
        end
        tests_run++;
        if (i_line !== exp_line || i_line[31:0] !== 32'hA0 || i_line[255:224] !== 32'hA7) begin
            fails++; $display("FAIL ifill_line: got %h, required %h", i_line, exp_line);
        end
        i_req = 1'b0;
        write_miss_repair = 1'b0;
        tick;
        tests_run++;
        if (i_done !== 1'b0 || i_done_cnt - id0 != 1 || rd_cnt - rd0 != 1 || rep_cnt - rep0 != 0) begin
            fails++;
            $display("FAIL ifill_counts: i_done=%b pulses=%0d reads=%0d repairs=%0d, required 0 1 1 0",
                     i_done, i_done_cnt - id0, rd_cnt - rd0, rep_cnt - rep0);
        end
        $display("[TB] test_ifill done");
    endtask

    task automatic test_wb_priority;
        bit ok;
        int rd0;
        logic [31:0] ia, da;
        logic [255:0] wd;
        do_reset;
        rd0 = rd_cnt;
        ia = $urandom; da = $urandom;
        for (int w = 0; w < 8; w++) wd[32*w +: 32] = $urandom;
        d_req = 1'b1; d_we = 1'b1; d_addr = da; d_wdata = wd; d_wmask = 32'hFFFF_FFFF;
        i_req = 1'b1; i_addr = ia;
        wait_wr(ok);
        tests_run++;
        if (!ok || rd_cnt != rd0) begin
            fails++; $display("FAIL wb_first: write_seen=%b reads_before=%0d, required 1 0", ok, rd_cnt - rd0);
        end
        tests_run++;
        if (waddr !== (da & ~32'h1F) || wmask !== 32'hFFFF_FFFF || wdata !== wd) begin
            fails++; $display("FAIL wb_fields: waddr=%h wmask=%h, required %h ffffffff", waddr, wmask, da & ~32'h1F);
        end
        tick;
        tests_run++;
        if (waddr_valid !== 1'b0 || d_done !== 1'b0 || raddr_valid !== 1'b0) begin
            fails++; $display("FAIL wb_wait: waddr_valid=%b d_done=%b, required 0 0", waddr_valid, d_done);
        end
        tick;
        tests_run++;
        if (d_done !== 1'b1 || d_line !== 256'h0) begin
            fails++; $display("FAIL wb_done: d_done=%b d_line=%h, required 1 and zero line", d_done, d_line);
        end
        d_req = 1'b0;
        wait_rd(ok);
        tests_run++;
        if (!ok || raddr !== (ia & ~32'h1F)) begin
            fails++; $display("FAIL wb_then_ifill: seen=%b raddr=%h, required 1 %h", ok, raddr, ia & ~32'h1F);
        end
        tick;
        make_beats;
        send_beats(0, 8);
        tests_run++;
        if (i_done !== 1'b1 || i_line !== exp_line) begin
            fails++; $display("FAIL wb_ifill_line: i_done=%b line=%h, required 1 %h", i_done, i_line, exp_line);
        end
        i_req = 1'b0;
        tick;
        $display("[TB] test_wb_priority done");
    endtask

    task automatic test_alternate;
        bit ok;
        bit exp_d;
        logic [31:0] ai, ad;
        do_reset;
        ai = $urandom & ~32'h3F;
        ad = ai | 32'h20;
        i_req = 1'b1; i_addr = ai | 32'(($urandom_range(0, 31)));
        d_req = 1'b1; d_we = 1'b0; d_addr = ad;
        for (int g = 0; g < 4; g++) begin
            exp_d = (g % 2) == 1;
            wait_rd(ok);
            tests_run++;
            if (!ok || raddr !== (exp_d ? ad : ai)) begin
                fails++; $display("FAIL alt_grant%0d: raddr=%h, required %h", g, raddr, exp_d ? ad : ai);
            end
            tick;
            make_beats;
            send_beats(0, 8);
            tests_run++;
            if (i_done !== !exp_d || d_done !== exp_d || (exp_d ? d_line : i_line) !== exp_line) begin
                fails++;
                $display("FAIL alt_done%0d: i_done=%b d_done=%b line=%h, required side D=%b line %h",
                         g, i_done, d_done, exp_d ? d_line : i_line, exp_d, exp_line);
            end
            tick;
        end
        i_req = 1'b0; d_req = 1'b0;
        tick;
        $display("[TB] test_alternate done");
    endtask

    task automatic test_read_repair;
        bit ok;
        int rep0;
        do_reset;
        rep0 = rep_cnt;
        i_req = 1'b1; i_addr = $urandom;
        wait_rd(ok);
        tick;
        make_beats;
        send_beats(0, 3);
        read_repair_request = 1'b1;
        missed_addr = 32'h2000_0010;
        tick;
        read_repair_request = 1'b0;
        tests_run++;
        if (repair_resolved !== 1'b1) begin fails++; $display("FAIL rrep_resolved: got %b, required 1", repair_resolved); end
        tick;
        missed_addr = $urandom;
        tests_run++;
        if (repair_resolved !== 1'b0 || raddr_valid !== 1'b1 || raddr !== 32'h2000_0000 || rep_cnt - rep0 != 1) begin
            fails++;
            $display("FAIL rrep_reissue: rr=%b raddr_valid=%b raddr=%h pulses=%0d, required 0 1 20000000 1",
                     repair_resolved, raddr_valid, raddr, rep_cnt - rep0);
        end
        tick;
        make_beats;
        send_beats(0, 7);
        tests_run++;
        if (i_done !== 1'b0) begin fails++; $display("FAIL rrep_early_done: i_done=%b after 7 fresh beats, required 0", i_done); end
        send_beats(7, 8);
        tests_run++;
        if (i_done !== 1'b1 || i_line !== exp_line) begin
            fails++; $display("FAIL rrep_line: i_done=%b line=%h, required 1 %h", i_done, i_line, exp_line);
        end
        i_req = 1'b0;
        tick;
        $display("[TB] test_read_repair done");
    endtask

    task automatic test_write_repair;
        bit ok;
        int wr0;
        logic [31:0] ma, mk;
        logic [255:0] wd;
        do_reset;
        wr0 = wr_cnt;
        for (int w = 0; w < 8; w++) wd[32*w +: 32] = $urandom;
        mk = $urandom; ma = $urandom;
        d_req = 1'b1; d_we = 1'b1; d_addr = $urandom; d_wdata = wd; d_wmask = mk;
        wait_wr(ok);
        tick;
        write_miss_repair = 1'b1;
        missed_addr = ma;
        tick;
        write_miss_repair = 1'b0;
        tests_run++;
        if (repair_resolved !== 1'b1 || d_done !== 1'b0) begin
            fails++; $display("FAIL wrep_resolved: rr=%b d_done=%b, required 1 0", repair_resolved, d_done);
        end
        tick;
        tests_run++;
        if (waddr_valid !== 1'b1 || waddr !== (ma & ~32'h1F) || wdata !== wd || wmask !== mk) begin
            fails++; $display("FAIL wrep_reissue: waddr_valid=%b waddr=%h, required 1 %h", waddr_valid, waddr, ma & ~32'h1F);
        end
        tick;
        tests_run++;
        if (d_done !== 1'b0) begin fails++; $display("FAIL wrep_wait: d_done=%b in WR_WAIT, required 0", d_done); end
        tick;
        tests_run++;
        if (d_done !== 1'b1 || wr_cnt - wr0 != 2) begin
            fails++; $display("FAIL wrep_done: d_done=%b writes=%0d, required 1 2", d_done, wr_cnt - wr0);
        end
        d_req = 1'b0;
        tick;
        $display("[TB] test_write_repair done");
    endtask

    task automatic test_reset_mid;
        bit ok;
        int id0;
        logic [1060:0] all_out;
        logic [31:0] a;
        do_reset;
        id0 = i_done_cnt;
        i_req = 1'b1; i_addr = $urandom;
        wait_rd(ok);
        tick;
        make_beats;
        send_beats(0, 4);
        rdata = beats[4];
        rdata_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        all_out = {raddr_valid, waddr_valid, i_done, d_done, repair_resolved,
                   raddr, waddr, wmask, wdata, i_line, d_line};
        tests_run++;
        if (all_out !== '0) begin
            fails++; $display("FAIL rstmid_outputs: some output nonzero (raddr_valid=%b i_done=%b), required all 0", raddr_valid, i_done);
        end
        rdata_valid = 1'b0;
        i_req = 1'b0;
        repeat (3) tick;
        rst_n = 1'b1;
        repeat (12) tick;
        tests_run++;
        if (i_done_cnt != id0) begin
            fails++; $display("FAIL rstmid_no_done: %0d done pulses, required 0", i_done_cnt - id0);
        end
        a = $urandom;
        i_req = 1'b1; i_addr = a;
        wait_rd(ok);
        tests_run++;
        if (!ok || raddr !== (a & ~32'h1F)) begin
            fails++; $display("FAIL rstmid_reissue: seen=%b raddr=%h, required 1 %h", ok, raddr, a & ~32'h1F);
        end
        tick;
        make_beats;
        send_beats(0, 8);
        tests_run++;
        if (i_done !== 1'b1 || i_line !== exp_line) begin
            fails++; $display("FAIL rstmid_fresh: i_done=%b line=%h, required 1 %h", i_done, i_line, exp_line);
        end
        i_req = 1'b0;
        tick;
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        test_reset;
        test_ifill;
        test_wb_priority;
        test_alternate;
        test_read_repair;
        test_write_repair;
        test_reset_mid;
        tests_run++;
        if (overlap_cnt != 0) begin
            fails++; $display("FAIL strobe_overlap: %0d cycles with both strobes, required 0", overlap_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
